// File: rtl/genesis_pad_reader.sv
// Genesis controller reader for NUM_PADS pads sharing one select line.
// Each rising edge of vga_vs starts one 8-phase select scan. The scan decodes
// 3/6-button pads and flags unplugged ones, then commits the results with a
// one-cycle valid strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | select high, waiting for a synced vga_vs rising edge
// SCAN  | stepping select through 8 phases, sampling at each step end
// DONE  | one cycle, results visible with valid high, back to IDLE
module genesis_pad_reader #(
    parameter int NUM_PADS        = 2,
    parameter int SEL_HALF_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vga_vs,
    input  logic [6*NUM_PADS-1:0]   pad_pins,
    output logic                    select_out,
    output logic [12*NUM_PADS-1:0]  buttons,
    output logic [12*NUM_PADS-1:0]  pressed,
    output logic [NUM_PADS-1:0]     six_button,
    output logic [NUM_PADS-1:0]     connected,
    output logic                    valid
);

    localparam int TW = $clog2(SEL_HALF_CYCLES);
    localparam logic [TW-1:0] T_LOAD = TW'(SEL_HALF_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [2:0]          step, step_nx;
    logic [TW-1:0]       timer, timer_nx;
    logic                sample_now, commit;

    logic                vs_s1, vs_s2, vs_prev, vs_rise;
    logic [6*NUM_PADS-1:0] pin_s1, pin_s2;
    logic [6*NUM_PADS-1:0] pin_act;

    // Inverted (1 = pin low) samples kept only for the bits the decode uses.
    logic [4*NUM_PADS-1:0] samp0;   // {start_c, a_b, right, left}
    logic [6*NUM_PADS-1:0] samp1;   // full select-high word
    logic [4*NUM_PADS-1:0] samp4;   // direction pins for 6-button detect
    logic [4*NUM_PADS-1:0] samp5;   // {mode, X, Y, Z} pins

    logic [12*NUM_PADS-1:0] btn_new;
    logic [NUM_PADS-1:0]    six_new, conn_new;

    assign vs_rise = vs_s2 & ~vs_prev;
    assign pin_act = ~pin_s2;

    // Two-flop synchronisers for vsync and pad pins, plus edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_prev <= 1'b0;
            pin_s1  <= '0;
            pin_s2  <= '0;
        end else begin
            vs_s1   <= vga_vs;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
            pin_s1  <= pad_pins;
            pin_s2  <= pin_s1;
        end
    end

    // FSM state, step and phase down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            step  <= '0;
            timer <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            timer <= timer_nx;
        end
    end

    // Next-state logic; the timer reaching zero marks the last clock of a step.
    always_comb begin
        state_nx   = state;
        step_nx    = step;
        timer_nx   = timer;
        sample_now = 1'b0;
        commit     = 1'b0;
        select_out = 1'b1;
        case (state)
            S_IDLE: begin
                if (vs_rise) begin
                    state_nx = S_SCAN;
                    step_nx  = 3'd0;
                    timer_nx = T_LOAD;
                end
            end
            S_SCAN: begin
                select_out = step[0];
                if (timer == '0) begin
                    sample_now = 1'b1;
                    timer_nx   = T_LOAD;
                    if (step == 3'd7) begin
                        state_nx = S_DONE;
                        commit   = 1'b1;
                    end else begin
                        step_nx = step + 3'd1;
                    end
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Capture the pin words of the steps that carry information.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp0 <= '0;
            samp1 <= '0;
            samp4 <= '0;
            samp5 <= '0;
        end else if (sample_now) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                case (step)
                    3'd0: samp0[4*p +: 4] <= pin_act[6*p+2 +: 4];
                    3'd1: samp1[6*p +: 6] <= pin_act[6*p +: 6];
                    3'd4: samp4[4*p +: 4] <= pin_act[6*p +: 4];
                    3'd5: samp5[4*p +: 4] <= pin_act[6*p +: 4];
                    default: ;
                endcase
            end
        end
    end

    // Decode the samples into per-pad button words; extra buttons need a 6-button pad.
    always_comb begin
        btn_new  = '0;
        six_new  = '0;
        conn_new = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            conn_new[p] = samp0[4*p+1] & samp0[4*p];
            six_new[p]  = conn_new[p] & (&samp4[4*p +: 4]);
            if (conn_new[p]) begin
                btn_new[12*p +: 8] = {samp0[4*p+3], samp1[6*p+5], samp1[6*p+4],
                                      samp0[4*p+2], samp1[6*p+3], samp1[6*p+2],
                                      samp1[6*p+1], samp1[6*p]};
                if (six_new[p]) begin
                    btn_new[12*p+8 +: 4] = {samp5[4*p+3], samp5[4*p], samp5[4*p+1],
                                            samp5[4*p+2]};
                end
            end
        end
    end

    // Result registers: updated on entry to DONE, so valid and results coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buttons    <= '0;
            pressed    <= '0;
            six_button <= '0;
            connected  <= '0;
            valid      <= 1'b0;
        end else begin
            valid   <= commit;
            pressed <= commit ? (btn_new & ~buttons) : '0;
            if (commit) begin
                buttons    <= btn_new;
                six_button <= six_new;
                connected  <= conn_new;
            end
        end
    end

endmodule

// File: tb/tb_genesis_pad_reader.sv
// Testbench for genesis_pad_reader with two behavioural Genesis pads.
module tb_genesis_pad_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_vs;
    logic [11:0] pad_pins;
    logic        select_out;
    logic [23:0] buttons, pressed;
    logic [1:0]  six_button, connected;
    logic        valid;

    // Pad holdings are active-high in the 12-bit button word layout.
    logic [11:0] held0, held1;
    logic        six1, plug1;

    int n_cmp = 0;
    int n_err = 0;

    int   fall_cnt = 0;
    int   hi_cnt   = 0;
    logic sel_prev = 1'b1;

    genesis_pad_reader #(.NUM_PADS(2), .SEL_HALF_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_vs     (vga_vs),
        .pad_pins   (pad_pins),
        .select_out (select_out),
        .buttons    (buttons),
        .pressed    (pressed),
        .six_button (six_button),
        .connected  (connected),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    // Pad select-edge counter; a long select-high period resets it like the real pad timeout.
    always @(negedge clk) begin
        sel_prev <= select_out;
        hi_cnt   <= select_out ? ((hi_cnt < 1000) ? hi_cnt + 1 : hi_cnt) : 0;
        if (!select_out && sel_prev)
            fall_cnt <= fall_cnt + 1;
        else if (select_out && hi_cnt > 20)
            fall_cnt <= 0;
    end

    function automatic logic [5:0] pad_drive(input logic sel, input int cnt,
                                             input logic [11:0] h, input logic six,
                                             input logic plug);
        if (!plug) return 6'h3F;
        if (sel) begin
            if (six && cnt == 3) return ~{h[6], h[5], h[11], h[8], h[9], h[10]};
            return ~{h[6], h[5], h[3], h[2], h[1], h[0]};
        end
        if (six && cnt == 3) return ~{h[7], h[4], 4'b1111};
        if (six && cnt == 4) return ~{h[7], h[4], 4'b0000};
        return ~{h[7], h[4], 2'b11, h[1], h[0]};
    endfunction

    // Pad 0 is always a plugged-in 3-button pad.
    always_comb begin
        pad_pins = {pad_drive(select_out, fall_cnt, held1, six1, plug1),
                    pad_drive(select_out, fall_cnt, held0, 1'b0, 1'b1)};
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse vga_vs and run until valid; lat = cycles from first select-low cycle to valid.
    task automatic run_frame(output int lat, output bit got);
        int fall_at;
        fall_at = -1;
        got = 1'b0;
        lat = -1;
        vga_vs = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 2) vga_vs = 1'b0;
            if (fall_at < 0 && !select_out) fall_at = i;
            if (valid) begin
                got = 1'b1;
                lat = i - fall_at;
                break;
            end
        end
        vga_vs = 1'b0;
    endtask

    typedef struct {
        logic [11:0] h0;
        logic [11:0] h1;
        logic        six1;
        logic        plug1;
        logic [23:0] eb;
        logic [23:0] ep;
        logic [1:0]  es;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   lat;
        bit   got;
        int   vcnt, fcnt;
        logic prev_sel;

        // Frames run in order; expected pressed depends on the preceding frame.
        vecs[0] = '{12'h000, 12'h000, 1'b1, 1'b1, 24'h000000, 24'h000000, 2'b10, 2'b11};
        vecs[1] = '{12'h081, 12'h410, 1'b1, 1'b1, 24'h410081, 24'h410081, 2'b10, 2'b11};
        vecs[2] = '{12'h081, 12'h410, 1'b1, 1'b1, 24'h410081, 24'h000000, 2'b10, 2'b11};
        vecs[3] = '{12'h000, 12'h000, 1'b1, 1'b0, 24'h000000, 24'h000000, 2'b00, 2'b01};
        vecs[4] = '{12'h000, 12'h040, 1'b0, 1'b1, 24'h040000, 24'h040000, 2'b00, 2'b11};
        vecs[5] = '{12'h0F5, 12'hF20, 1'b1, 1'b1, 24'hF200F5, 24'hF200F5, 2'b10, 2'b11};
        vecs[6] = '{12'h0F5, 12'h048, 1'b0, 1'b1, 24'h0480F5, 24'h048000, 2'b00, 2'b11};

        reset  = 1'b1;
        vga_vs = 1'b0;
        held0  = '0;
        held1  = '0;
        six1   = 1'b1;
        plug1  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_select", {23'd0, select_out}, 24'd1);
        check("reset_buttons", buttons, 24'd0);
        check("reset_flags", {20'd0, six_button, connected}, 24'd0);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            held0 = vecs[v].h0;
            held1 = vecs[v].h1;
            six1  = vecs[v].six1;
            plug1 = vecs[v].plug1;
            run_frame(lat, got);
            check($sformatf("v%0d_valid_seen", v), {23'd0, got}, 24'd1);
            // valid comes in the 33rd cycle counting the first select-low cycle as 1.
            check($sformatf("v%0d_latency", v), 24'(lat), 24'd32);
            check($sformatf("v%0d_buttons", v), buttons, vecs[v].eb);
            check($sformatf("v%0d_pressed", v), pressed, vecs[v].ep);
            check($sformatf("v%0d_six", v), {22'd0, six_button}, {22'd0, vecs[v].es});
            check($sformatf("v%0d_conn", v), {22'd0, connected}, {22'd0, vecs[v].ec});
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_drop", v), {23'd0, valid}, 24'd0);
            check($sformatf("v%0d_pressed_drop", v), pressed, 24'd0);
            check($sformatf("v%0d_buttons_hold", v), buttons, vecs[v].eb);
            repeat (30) @(posedge clk);
            #1;
        end

        // Second vsync edge mid-scan must be neither honoured nor queued.
        vcnt = 0;
        fcnt = 0;
        prev_sel = 1'b1;
        fork
            begin
                vga_vs = 1'b1;
                repeat (3) @(posedge clk);
                #1 vga_vs = 1'b0;
                repeat (10) @(posedge clk);
                #1 vga_vs = 1'b1;
                repeat (3) @(posedge clk);
                #1 vga_vs = 1'b0;
            end
            begin
                for (int i = 0; i < 90; i++) begin
                    @(posedge clk); #1;
                    if (valid) vcnt++;
                    if (!select_out && prev_sel) fcnt++;
                    prev_sel = select_out;
                end
            end
        join
        check("double_vs_valids", 24'(vcnt), 24'd1);
        check("double_vs_low_pulses", 24'(fcnt), 24'd4);
        repeat (30) @(posedge clk);
        #1;

        // Reset during step 3 aborts the scan.
        vga_vs = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 2) vga_vs = 1'b0;
            if (!select_out) begin
                got = 1'b1;
                break;
            end
        end
        vga_vs = 1'b0;
        check("abort_scan_started", {23'd0, got}, 24'd1);
        check("abort_buttons_before", buttons, 24'h0480F5);
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_select", {23'd0, select_out}, 24'd1);
        check("abort_buttons", buttons, 24'd0);
        check("abort_pressed", pressed, 24'd0);
        check("abort_flags", {19'd0, valid, six_button, connected}, 24'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        vcnt = 0;
        fcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) vcnt++;
            if (!select_out) fcnt++;
        end
        check("abort_no_valid", 24'(vcnt), 24'd0);
        check("abort_select_idle", 24'(fcnt), 24'd0);

        held0 = 12'h081;
        held1 = 12'h410;
        six1  = 1'b1;
        plug1 = 1'b1;
        run_frame(lat, got);
        check("post_reset_valid_seen", {23'd0, got}, 24'd1);
        check("post_reset_latency", 24'(lat), 24'd32);
        check("post_reset_buttons", buttons, 24'h410081);
        check("post_reset_pressed", pressed, 24'h410081);
        check("post_reset_flags", {20'd0, six_button, connected}, 24'h00000B);
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
